wb_stage: RTL

Write-back stage of the five-stage pipelined MIPS CPU, between the MEM stage and the register file in ID. It holds the MEM/WB pipeline register and selects ALU result or load data. It waits on a variable-latency data memory and drives the register-file write port (RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb) that the ID stage consumes. It also stalls the pipeline upstream while a load is outstanding.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_retire_counter.sv | 21 ++
 rtl/wb_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared state type, default widths and wait-counter sizing for the write-back stage
package wb_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } wb_state_e;

  function automatic int wait_cnt_w(input int wait_max);
    return $clog2(wait_max + 1);
  endfunction

  localparam int WAIT_CNT_W = wait_cnt_w(WAIT_MAX_DEF);

endpackage

// File: rtl/wb_retire_counter.sv
// rtl/wb_retire_counter.sv - free-running count of instructions retired into the WB register
module wb_retire_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, load-wait FSM and register-file write port
// Optional retire counter output enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_mem,
  input  logic              RegWrite_mem,
  input  logic              MemtoReg_mem,
  input  logic              MemRead_mem,
  input  logic [ADDR_W-1:0] RegWriteAddr_mem,
  input  logic [DATA_W-1:0] ALUResult_mem,
  input  logic [DATA_W-1:0] MemDout,
  input  logic              MemReady,
  output logic              stall_mem,
  output logic              valid_wb,
  output logic              RegWrite_wb,
  output logic [ADDR_W-1:0] RegWriteAddr_wb,
  output logic [DATA_W-1:0] RegWriteData_wb,
  output logic              mem_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  localparam int CNT_W = wait_cnt_w(WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX);

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              is_load;
  logic              capture;
  logic              stall_c;

  assign is_load = valid_mem & MemRead_mem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_load && !MemReady) begin
          stall_c = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          capture = 1'b1;
        end
      end
      WAIT: begin
        // MEM-stage inputs are frozen by the stall, so they still describe the pending load
        if (MemReady) begin
          capture = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          if (cnt_q == WAIT_LAST) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ERR: begin
        stall_c = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Anything not captured becomes a bubble with a cleared payload
  always_comb begin
    valid_d = capture & valid_mem;
    we_d    = valid_d & RegWrite_mem & (RegWriteAddr_mem != '0);
    addr_d  = capture ? RegWriteAddr_mem : '0;
    data_d  = '0;
    if (capture) begin
      data_d = MemtoReg_mem ? MemDout : ALUResult_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign stall_mem       = reset & stall_c;
  assign mem_err         = (state_q == ERR);
  assign valid_wb        = valid_q;
  assign RegWrite_wb     = we_q;
  assign RegWriteAddr_wb = addr_q;
  assign RegWriteData_wb = data_q;

`ifdef WB_RETIRE_CNT_EN
  wb_retire_counter u_retire_counter (
    .clk   (clk),
    .reset (reset),
    .inc_i (valid_d),
    .cnt_o (retire_cnt)
  );
`endif

endmodule
